// File: rtl/pong_pkg.sv
// Shared Pong definitions: paddle command codes, playfield geometry, paddle FSM encoding.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package pong_pkg;

  localparam logic [1:0] CMD_HOLD = 2'b00;
  localparam logic [1:0] CMD_UP   = 2'b01;
  localparam logic [1:0] CMD_DOWN = 2'b10;

  localparam int SCREEN_H      = 480;
  localparam int PADDLE_HEIGHT = 50;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } paddle_state_t;

endpackage

// File: rtl/paddle_ctrl_if.sv
// Paddle command/position bundle between a command source (AI or buttons) and paddle_ctrl.
// Latency: n/a (wires only).
// Backpressure: none; commands are sampled on movement ticks, position is always valid.
interface paddle_ctrl_if;

  logic       enable;
  logic [1:0] move_cmd;
  logic [9:0] paddle_pos;
  logic       at_top;
  logic       at_bottom;
  logic       moving;

  // Command source side
  modport master (
    output enable, move_cmd,
    input  paddle_pos, at_top, at_bottom, moving
  );

  // Paddle controller side
  modport slave (
    input  enable, move_cmd,
    output paddle_pos, at_top, at_bottom, moving
  );

endinterface

// File: rtl/paddle_ctrl_tick_gen.sv
// Movement-rate prescaler: one-cycle registered tick after every DIV enabled cycles.
// Latency: tick is high the cycle after the count reaches DIV-1.
// Backpressure: none; enable low clears the count and suppresses tick.
module tick_gen #(
  parameter int DIV = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int            W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0]  LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  // Free-running 0..DIV-1 counter while enabled; registered tick on the wrap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (!enable) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == LAST);
      cnt  <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/paddle_ctrl.sv
// Paddle position integrator: rate-limited up/down moves, clamped to the playfield.
// Latency: paddle_pos updates on the clock edge ending a tick cycle (1 clk after tick).
// Backpressure: none; move_cmd is only sampled on ticks, enable low freezes the paddle.
// Optional PADDLE_ACCEL_EN: after ACCEL_TICKS same-direction ticks the step becomes STEP_FAST.
module paddle_ctrl #(
  parameter int STEP_DIV      = 500000,
  parameter int STEP_SLOW     = 2,
`ifdef PADDLE_ACCEL_EN
  parameter int STEP_FAST     = 4,
  parameter int ACCEL_TICKS   = 8,
`endif
  parameter int Y_MIN         = 0,
  parameter int Y_MAX         = pong_pkg::SCREEN_H,
  parameter int PADDLE_HEIGHT = pong_pkg::PADDLE_HEIGHT,
  parameter int RESET_POS     = 215
) (
  input  logic          clk,
  input  logic          reset,
  paddle_ctrl_if.slave  bus
);

  import pong_pkg::*;

  localparam int                 Y_LIMIT = Y_MAX - PADDLE_HEIGHT;
  localparam logic signed [10:0] LIM_LO  = 11'(Y_MIN);
  localparam logic signed [10:0] LIM_HI  = 11'(Y_LIMIT);

  logic          tick;
  paddle_state_t state_q, state_d;
  logic [9:0]    pos_q, pos_d;
  logic signed [10:0] pos_ext, step, sum;

`ifdef PADDLE_ACCEL_EN
  localparam int              RUN_W = $clog2(ACCEL_TICKS + 1);
  localparam logic [RUN_W-1:0] RUN_SAT = RUN_W'(ACCEL_TICKS);
  logic [RUN_W-1:0] run_q, run_d;
`endif

  tick_gen #(
    .DIV (STEP_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .enable (bus.enable),
    .tick   (tick)
  );

  // Zero-extend so the clamp compares cannot wrap below zero or above 1023
  assign pos_ext = signed'({1'b0, pos_q});

  // Next state, run length and clamped position; everything holds between ticks
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    step    = 11'(STEP_SLOW);
    sum     = pos_ext;
`ifdef PADDLE_ACCEL_EN
    run_d   = run_q;
`endif
    if (!bus.enable) begin
      state_d = ST_IDLE;
`ifdef PADDLE_ACCEL_EN
      run_d   = '0;
`endif
    end else if (tick) begin
      case (bus.move_cmd)
        CMD_UP:   state_d = ST_UP;
        CMD_DOWN: state_d = ST_DOWN;
        CMD_HOLD: state_d = ST_IDLE;
        2'b11:    state_d = ST_IDLE;
      endcase
`ifdef PADDLE_ACCEL_EN
      // Run length counts repeated ticks in one direction; any change restarts it
      if (state_d != ST_IDLE && state_d == state_q)
        run_d = (run_q == RUN_SAT) ? run_q : run_q + 1'b1;
      else
        run_d = '0;
      if (run_d == RUN_SAT)
        step = 11'(STEP_FAST);
`endif
      if (state_d == ST_UP) begin
        sum = pos_ext - step;
        if (sum < LIM_LO) sum = LIM_LO;
      end else if (state_d == ST_DOWN) begin
        sum = pos_ext + step;
        if (sum > LIM_HI) sum = LIM_HI;
      end
      pos_d = 10'(sum);
    end
  end

  // State, position and run-length registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pos_q   <= 10'(RESET_POS);
`ifdef PADDLE_ACCEL_EN
      run_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
`ifdef PADDLE_ACCEL_EN
      run_q   <= run_d;
`endif
    end
  end

  assign bus.paddle_pos = pos_q;
  assign bus.at_top     = (pos_q == 10'(Y_MIN));
  assign bus.at_bottom  = (pos_q == 10'(Y_LIMIT));
  assign bus.moving     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_paddle_ctrl.sv
// Self-checking bench for paddle_ctrl with STEP_DIV=4: directed table, corner sequences,
// and randomized commands/enable/reset compared every cycle against a behavioural model.
module tb_paddle_ctrl;

  localparam int DIV  = 4;
  localparam int Y_HI = 480 - 50;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  paddle_ctrl_if pif ();

  paddle_ctrl #(
    .STEP_DIV (DIV)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (pif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: a move happens on every DIV-th consecutive enabled edge
  // (counted from reset release or re-enable), using the command present at the next edge.
  int m_pos   = 215;
  int m_dir   = 0;
  int m_run   = 0;
  int m_edges = 0;
  bit m_tick  = 1'b0;

  always @(posedge clk or posedge reset) begin
    int nd, st;
    if (reset) begin
      m_pos = 215; m_dir = 0; m_run = 0; m_edges = 0; m_tick = 1'b0;
    end else if (!pif.enable) begin
      m_dir = 0; m_run = 0; m_edges = 0; m_tick = 1'b0;
    end else begin
      if (m_tick) begin
        nd = (pif.move_cmd == 2'b01) ? -1 : (pif.move_cmd == 2'b10) ? 1 : 0;
        if (nd == 0) begin
          m_dir = 0;
          m_run = 0;
        end else begin
          m_run = (nd == m_dir) ? ((m_run < 8) ? m_run + 1 : 8) : 0;
          m_dir = nd;
          st = 2;
`ifdef PADDLE_ACCEL_EN
          if (m_run == 8) st = 4;
`endif
          m_pos = m_pos + nd * st;
          if (m_pos < 0)    m_pos = 0;
          if (m_pos > Y_HI) m_pos = Y_HI;
        end
      end
      m_edges++;
      m_tick = ((m_edges % DIV) == 0);
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_on && !reset) begin
      check("model_pos",    int'(pif.paddle_pos), m_pos);
      check("model_moving", int'(pif.moving),     (m_dir != 0) ? 1 : 0);
      check("model_top",    int'(pif.at_top),     (m_pos == 0) ? 1 : 0);
      check("model_bottom", int'(pif.at_bottom),  (m_pos == Y_HI) ? 1 : 0);
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Async reset between edges, checked before any clock edge, then aligned to the tick grid
  task automatic apply_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_pos",    int'(pif.paddle_pos), 215);
    check("rst_moving", int'(pif.moving),     0);
    check("rst_top",    int'(pif.at_top),     0);
    check("rst_bottom", int'(pif.at_bottom),  0);
    chk_on = 1'b1;
    @(negedge clk);
    reset        = 1'b0;
    pif.enable   = 1'b1;
    pif.move_cmd = 2'b00;
    wait_cyc(DIV);
  endtask

  typedef struct {
    logic [1:0] cmd;
    int         ticks;
    int         pos;
    int         moving;
  } vec_t;

  vec_t tbl[6];
  int   p0;

  initial begin
    tbl[0] = '{cmd: 2'b10, ticks: 3, pos: 221, moving: 1};
    tbl[1] = '{cmd: 2'b00, ticks: 1, pos: 221, moving: 0};
    tbl[2] = '{cmd: 2'b01, ticks: 2, pos: 217, moving: 1};
    tbl[3] = '{cmd: 2'b11, ticks: 1, pos: 217, moving: 0};
    tbl[4] = '{cmd: 2'b10, ticks: 5, pos: 227, moving: 1};
    tbl[5] = '{cmd: 2'b01, ticks: 4, pos: 219, moving: 1};

    pif.enable   = 1'b0;
    pif.move_cmd = 2'b00;

    apply_reset();

    // Directed table: each entry holds a command for a whole number of ticks
    for (int i = 0; i < 6; i++) begin
      pif.move_cmd = tbl[i].cmd;
      wait_cyc(DIV * tbl[i].ticks);
      check($sformatf("tbl%0d_pos", i),    int'(pif.paddle_pos), tbl[i].pos);
      check($sformatf("tbl%0d_moving", i), int'(pif.moving),     tbl[i].moving);
    end

    // Reset mid-motion, then steady downward stepping and a reversal
    apply_reset();
    pif.move_cmd = 2'b10;
`ifdef PADDLE_ACCEL_EN
    wait_cyc(DIV * 8);
    check("accel_slow8", int'(pif.paddle_pos), 231);
    wait_cyc(DIV);
    check("accel_fast1", int'(pif.paddle_pos), 235);
    wait_cyc(DIV);
    check("accel_fast2", int'(pif.paddle_pos), 239);
    pif.move_cmd = 2'b01;
    wait_cyc(DIV);
    check("accel_flip", int'(pif.paddle_pos), 237);
`else
    wait_cyc(DIV * 10);
    check("slow_10", int'(pif.paddle_pos), 235);
    pif.move_cmd = 2'b01;
    wait_cyc(DIV);
    check("slow_flip", int'(pif.paddle_pos), 233);
`endif
    check("flip_moving", int'(pif.moving), 1);

    // Command pulses that never coincide with a tick must not move the paddle
    pif.move_cmd = 2'b00;
    wait_cyc(1);
    p0 = m_pos;
    pif.move_cmd = 2'b10;
    wait_cyc(2);
    pif.move_cmd = 2'b01;
    wait_cyc(1);
    pif.move_cmd = 2'b00;
    wait_cyc(1);
    check("pulse_pos",    int'(pif.paddle_pos), p0);
    check("pulse_moving", int'(pif.moving),     0);

    // Enable drop freezes, re-enable restarts the prescaler from zero
    apply_reset();
    pif.move_cmd = 2'b10;
    wait_cyc(DIV * 3);
    check("en_pre", int'(pif.paddle_pos), 221);
    pif.enable = 1'b0;
    wait_cyc(1);
    check("en_off_moving", int'(pif.moving), 0);
    wait_cyc(9);
    check("en_off_pos", int'(pif.paddle_pos), 221);
    pif.enable = 1'b1;
    wait_cyc(DIV);
    check("en_restart_hold", int'(pif.paddle_pos), 221);
    wait_cyc(1);
    check("en_restart_step",   int'(pif.paddle_pos), 223);
    check("en_restart_moving", int'(pif.moving),     1);

    // Bottom clamp
    apply_reset();
    pif.move_cmd = 2'b10;
`ifdef PADDLE_ACCEL_EN
    wait_cyc(DIV * 108);
`else
    wait_cyc(DIV * 107);
    check("bot_429",     int'(pif.paddle_pos), 429);
    check("bot_429_flag", int'(pif.at_bottom), 0);
    wait_cyc(DIV);
`endif
    check("bot_clamp",      int'(pif.paddle_pos), 430);
    check("bot_clamp_flag", int'(pif.at_bottom),  1);
    wait_cyc(DIV * 3);
    check("bot_hold",        int'(pif.paddle_pos), 430);
    check("bot_hold_moving", int'(pif.moving),     1);

    // Top clamp
    apply_reset();
    pif.move_cmd = 2'b01;
`ifdef PADDLE_ACCEL_EN
    wait_cyc(DIV * 108);
`else
    wait_cyc(DIV * 107);
    check("top_1",      int'(pif.paddle_pos), 1);
    check("top_1_flag", int'(pif.at_top),     0);
    wait_cyc(DIV);
`endif
    check("top_clamp",      int'(pif.paddle_pos), 0);
    check("top_clamp_flag", int'(pif.at_top),     1);
    wait_cyc(DIV * 3);
    check("top_hold",        int'(pif.paddle_pos), 0);
    check("top_hold_moving", int'(pif.moving),     1);

    // Randomized commands, enable glitches and occasional resets against the model
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (reset) reset = 1'b0;
      if ($urandom_range(0, 39) == 0) pif.move_cmd = 2'($urandom_range(0, 3));
      pif.enable = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 1999) == 0) reset = 1'b1;
    end
    @(negedge clk);
    reset = 1'b0;
    wait_cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
